alu_op_sequencer: RTL and testbench

Sequences the shared 64-bit-result ALU for the Mini SRC datapath. Accepts one operation request at a time over a valid/ready handshake, registers the operands onto the ALU's `y`/`b` inputs, drives the 5-bit ALU control code for the required number of cycles, and captures the 64-bit result into HI/LO. The response is held until the consumer accepts it. The block sits between the control unit, or any other requester, and the ALU instance.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_op_decode.sv | 12 +
 rtl/alu_op_sequencer.sv | 87 ++++++++
 tb/tb_alu_op_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and counter width shared by the ALU sequencer
// and anything else that needs to name ALU operations.
package alu_seq_pkg;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam int CNT_W = 4;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: classifies an ALU opcode as legal and/or multi-cycle (MUL/DIV).
module alu_op_decode
   import alu_seq_pkg::*;
(
   input  logic [4:0] opcode,
   output logic       legal,
   output logic       is_muldiv
);
   assign is_muldiv = opcode == OP_MUL || opcode == OP_DIV;
   assign legal = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
                                 OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT};
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: one-at-a-time ALU op sequencing with HI/LO capture and held response.
// Define ALU_SEQ_PERF_EN to add the op_count response counter output.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int MULDIV_WAIT = 4
) (
   input  logic        clock,
   input  logic        clear,
`ifdef ALU_SEQ_PERF_EN
   output logic [31:0] op_count,
`endif
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_opcode,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] alu_y,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_control,
   input  logic [63:0] alu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_hi,
   output logic [31:0] rsp_lo,
   output logic        rsp_err
);
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [4:0] op;
   logic legal, is_muldiv, accept, reject;

   alu_op_decode u_dec (.opcode(req_opcode), .legal(legal), .is_muldiv(is_muldiv));

   assign accept = req_valid && state == IDLE;
   // Errors bypass EXEC entirely so the ALU never sees an illegal code or a zero divisor.
   assign reject = !legal || (req_opcode == OP_DIV && req_b == '0);

   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      req_ready = state == IDLE;
      rsp_valid = state == RESP;
      alu_control = state == EXEC ? op : 5'b00000;
      case (state)
         IDLE: if (accept) begin
            state_nx = reject ? RESP : EXEC;
            cnt_nx = is_muldiv ? CNT_W'(MULDIV_WAIT - 1) : '0;
         end
         EXEC: begin
            state_nx = cnt == '0 ? RESP : EXEC;
            cnt_nx = cnt - CNT_W'(1);
         end
         default: state_nx = rsp_ready ? IDLE : RESP;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state <= IDLE;
         cnt <= '0;
         op <= '0;
         alu_y <= '0;
         alu_b <= '0;
         rsp_hi <= '0;
         rsp_lo <= '0;
         rsp_err <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         if (accept) begin
            op <= req_opcode;
            alu_y <= req_a;
            alu_b <= req_b;
            if (reject) {rsp_err, rsp_hi, rsp_lo} <= {1'b1, 64'b0};
         end
         if (state == EXEC && cnt == '0) {rsp_err, rsp_hi, rsp_lo} <= {1'b0, alu_result};
      end
   end

`ifdef ALU_SEQ_PERF_EN
   always_ff @(posedge clock) begin
      if (clear) op_count <= '0;
      else if (rsp_valid && rsp_ready) op_count <= op_count + 32'd1;
   end
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized self-checking bench with a multi-cycle ALU model
// and a request-level reference model. Honours ALU_SEQ_PERF_EN for op_count.
module tb_alu_op_sequencer;
   import alu_seq_pkg::*;
   localparam int W = 4;

   logic clock = 0;
   logic clear = 0;
   logic req_valid = 0, req_ready, rsp_valid, rsp_ready = 1, rsp_err;
   logic [4:0] req_opcode = 0, alu_control;
   logic [31:0] req_a = 0, req_b = 0, alu_y, alu_b, rsp_hi, rsp_lo;
   logic [63:0] alu_result;
   logic [4:0] held = 0;
   int tests = 0, fails = 0;
`ifdef ALU_SEQ_PERF_EN
   logic [31:0] op_count;
   logic [31:0] exp_count = 0;
`endif

   always #5 clock = ~clock;

   alu_op_sequencer #(.MULDIV_WAIT(W)) dut (
      .clock(clock), .clear(clear),
`ifdef ALU_SEQ_PERF_EN
      .op_count(op_count),
`endif
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_a(req_a), .req_b(req_b), .alu_y(alu_y), .alu_b(alu_b),
      .alu_control(alu_control), .alu_result(alu_result), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err));

   function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [4:0] s;
      s = b[4:0];
      case (op)
         OP_ADD:  return {32'd0, a + b};
         OP_SUB:  return {32'd0, a - b};
         OP_AND:  return {32'd0, a & b};
         OP_OR:   return {32'd0, a | b};
         OP_SHR:  return {32'd0, a >> s};
         OP_SHRA: return {32'd0, 32'($signed(a) >>> s)};
         OP_SHL:  return {32'd0, a << s};
         OP_ROR:  return {32'd0, (a >> s) | (a << (6'd32 - {1'b0, s}))};
         OP_ROL:  return {32'd0, (a << s) | (a >> (6'd32 - {1'b0, s}))};
         OP_MUL:  return {{32{a[31]}}, a} * {{32{b[31]}}, b};
         OP_DIV:  return {a % b, a / b};
         OP_NEG:  return {32'd0, -a};
         OP_NOT:  return {32'd0, ~a};
         default: return 64'hBAD0_BAD0_BAD0_BAD0;
      endcase
   endfunction

   // Multi-cycle ALU: MUL/DIV results become valid only in the W-th cycle the code is held.
   always_ff @(posedge clock) held <= alu_control != 0 ? held + 5'd1 : 5'd0;
   always_comb
      alu_result = ((alu_control == OP_MUL || alu_control == OP_DIV) && held < 5'(W - 1))
                   ? 64'hDEAD_BEEF_DEAD_BEEF : alu_fn(alu_control, alu_y, alu_b);

   // Request-level expectations: error flag, HI/LO, edges to rsp_valid, cycles in EXEC.
   function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic err, output logic [63:0] res, output int lat, output int ex);
      logic [4:0] legal_ops [13] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
                                     OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT};
      logic ok = 0;
      foreach (legal_ops[i]) if (legal_ops[i] == op) ok = 1;
      err = !ok || (op == OP_DIV && b == 0);
      res = err ? 64'd0 : alu_fn(op, a, b);
      ex = err ? 0 : (op == OP_MUL || op == OP_DIV) ? W : 1;
      lat = ex;
   endfunction

   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
      logic err;
      logic [63:0] res;
      int lat, ex, edges, execs;
      bit acc;
      ref_model(op, a, b, err, res, lat, ex);
      req_opcode = op; req_a = a; req_b = b; req_valid = 1; rsp_ready = hold == 0;
      acc = 0;
      for (int i = 0; i < 20 && !acc; i++) begin
         if (req_ready) acc = 1;
         @(posedge clock); #1;
      end
      req_valid = 0;
      tests++;
      if (!acc) begin fails++; $display("FAIL accept op=%b: req_ready=0 required 1", op); return; end
      edges = 0; execs = 0;
      while (!rsp_valid && edges < 40) begin
         if (alu_control != 0) begin
            execs++;
            tests++;
            if (alu_control !== op || alu_y !== a || alu_b !== b) begin
               fails++;
               $display("FAIL exec_drive op=%b: ctl=%b y=%h b=%h required ctl=%b y=%h b=%h", op, alu_control, alu_y, alu_b, op, a, b);
            end
         end
         @(posedge clock); #1; edges++;
      end
      tests++;
      if (edges !== lat) begin fails++; $display("FAIL latency op=%b: %0d edges required %0d", op, edges, lat); end
      tests++;
      if (execs !== ex) begin fails++; $display("FAIL exec_cycles op=%b: %0d required %0d", op, execs, ex); end
      tests++;
      if (rsp_err !== err || {rsp_hi, rsp_lo} !== res) begin
         fails++;
         $display("FAIL result op=%b a=%h b=%h: err=%b hi=%h lo=%h required err=%b hi=%h lo=%h",
                  op, a, b, rsp_err, rsp_hi, rsp_lo, err, res[63:32], res[31:0]);
      end
      for (int i = 0; i < hold; i++) begin
         req_valid = 1; req_opcode = OP_ADD; req_a = $urandom; req_b = $urandom;
         @(posedge clock); #1;
         tests++;
         if (rsp_valid !== 1 || req_ready !== 0 || alu_control !== 0 || rsp_err !== err || {rsp_hi, rsp_lo} !== res) begin
            fails++;
            $display("FAIL hold cyc=%0d: valid=%b ready=%b ctl=%b err=%b hi=%h lo=%h required 1 0 0 %b %h %h",
                     i, rsp_valid, req_ready, alu_control, rsp_err, rsp_hi, rsp_lo, err, res[63:32], res[31:0]);
         end
      end
      rsp_ready = 1;
      @(posedge clock); #1;
      req_valid = 0;
`ifdef ALU_SEQ_PERF_EN
      exp_count++;
      tests++;
      if (op_count !== exp_count) begin fails++; $display("FAIL op_count: %0d required %0d", op_count, exp_count); end
`endif
      tests++;
      if (req_ready !== 1 || rsp_valid !== 0 || alu_y !== a || alu_b !== b) begin
         fails++;
         $display("FAIL release op=%b: ready=%b valid=%b y=%h b=%h required 1 0 %h %h", op, req_ready, rsp_valid, alu_y, alu_b, a, b);
      end
   endtask

   task automatic test_reset();
      clear = 1;
      repeat (2) @(posedge clock);
      #1 clear = 0;
      tests++;
      if (req_ready !== 1 || rsp_valid !== 0 || rsp_err !== 0 || alu_control !== 0 ||
          rsp_hi !== 0 || rsp_lo !== 0 || alu_y !== 0 || alu_b !== 0) begin
         fails++;
         $display("FAIL reset: ready=%b valid=%b err=%b ctl=%b hi=%h lo=%h y=%h b=%h required 1 0 0 0 0 0 0 0",
                  req_ready, rsp_valid, rsp_err, alu_control, rsp_hi, rsp_lo, alu_y, alu_b);
      end
`ifdef ALU_SEQ_PERF_EN
      exp_count = 0;
      tests++;
      if (op_count !== 0) begin fails++; $display("FAIL reset_op_count: %0d required 0", op_count); end
`endif
   endtask

   task automatic test_add(); run_op(OP_ADD, 32'd5, 32'd7, 0); endtask
   task automatic test_mul(); run_op(OP_MUL, 32'h10000, 32'h10000, 0); endtask

   task automatic test_errors();
      run_op(OP_DIV, 32'd100, 32'd0, 0);
      run_op(5'b11111, 32'd1, 32'd2, 0);
      run_op(OP_DIV, 32'd100, 32'd7, 0);
   endtask

   task automatic test_backpressure();
      run_op(OP_NOT, 32'd0, 32'd0, 6);
   endtask

   task automatic test_reset_mid_mul();
      int seen;
      req_opcode = OP_MUL; req_a = 32'd3; req_b = 32'd9; req_valid = 1;
      @(posedge clock); #1;
      req_valid = 0;
      @(posedge clock); #1;
      tests++;
      if (alu_control !== OP_MUL) begin fails++; $display("FAIL mid_mul_exec: ctl=%b required %b", alu_control, OP_MUL); end
      clear = 1;
      @(posedge clock); #1;
      clear = 0;
      tests++;
      if (req_ready !== 1 || rsp_valid !== 0 || alu_control !== 0 || rsp_err !== 0 ||
          rsp_hi !== 0 || rsp_lo !== 0 || alu_y !== 0 || alu_b !== 0) begin
         fails++;
         $display("FAIL mid_mul_clear: ready=%b valid=%b ctl=%b err=%b hi=%h lo=%h y=%h b=%h required 1 0 0 0 0 0 0 0",
                  req_ready, rsp_valid, alu_control, rsp_err, rsp_hi, rsp_lo, alu_y, alu_b);
      end
      seen = 0;
      repeat (8) begin @(posedge clock); #1; seen += rsp_valid; end
      tests++;
      if (seen !== 0) begin fails++; $display("FAIL mid_mul_no_rsp: %0d valid cycles required 0", seen); end
`ifdef ALU_SEQ_PERF_EN
      exp_count = 0;
      tests++;
      if (op_count !== 0) begin fails++; $display("FAIL mid_mul_op_count: %0d required 0", op_count); end
`endif
   endtask

   task automatic test_random();
      logic [4:0] pool [15] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR,
                                OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT, 5'b00000, 5'b01100};
      for (int i = 0; i < 60; i++) begin
         logic [4:0] op;
         logic [31:0] b;
         op = $urandom_range(0, 5) == 0 ? 5'($urandom) : pool[$urandom_range(0, 14)];
         b = $urandom_range(0, 4) == 0 ? 32'd0 : $urandom;
         run_op(op, $urandom, b, $urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_errors();
      test_backpressure();
      test_reset_mid_mul();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
